// File: rtl/bp_table_ctrl.sv
// bp_table_ctrl: branch-history table of 2-bit saturating counters, shared
// one access per cycle between the fetch lookup port and the execute update
// port. After reset a multi-cycle sweep sets every entry to weakly not-taken.
//
// Optional feature macro: BP_STARVE_GUARD_EN
//   defined   -> after two consecutive update grants with a lookup waiting,
//                the lookup is forced through (grant pattern U,U,L,...).
//   undefined -> updates always win arbitration.
module bp_table_ctrl #(
    parameter int IDX_W = 4,
    parameter int PC_W  = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            lk_valid,
    input  logic [PC_W-1:0] lk_pc,
    output logic            lk_ready,
    output logic            pred_valid,
    output logic            pred_taken,
    input  logic            upd_valid,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_taken,
    output logic            upd_ready,
    output logic            init_busy
);

    localparam int DEPTH = 1 << IDX_W;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]       state_r;
    logic [IDX_W-1:0] sweep_idx_r;
    logic [1:0]       table_r [DEPTH];
    logic             pred_valid_r;
    logic             pred_taken_r;

    logic             run_s;
    logic             force_lk_s;
    logic             lk_acc_s;
    logic             upd_acc_s;
    logic [IDX_W-1:0] lk_idx_s;
    logic [IDX_W-1:0] upd_idx_s;
    logic             wr_en_s;
    logic [IDX_W-1:0] wr_idx_s;
    logic [1:0]       wr_data_s;
    logic             unused_pc_s;

    // Next value of a 2-bit saturating counter for a resolved outcome.
    function automatic logic [1:0] sat_next(input logic [1:0] cnt, input logic taken);
        logic [1:0] res;
        case (cnt)
            2'b00:   res = taken ? 2'b01 : 2'b00;
            2'b01:   res = taken ? 2'b10 : 2'b00;
            2'b10:   res = taken ? 2'b11 : 2'b01;
            2'b11:   res = taken ? 2'b11 : 2'b10;
            default: res = 2'b01;
        endcase
        return res;
    endfunction

    // Only the low PC bits index the table; upper bits alias by design.
    assign lk_idx_s    = lk_pc[IDX_W-1:0];
    assign upd_idx_s   = upd_pc[IDX_W-1:0];
    assign unused_pc_s = ^{lk_pc[PC_W-1:IDX_W], upd_pc[PC_W-1:IDX_W]};

    assign run_s = (state_r == ST_RUN);

`ifdef BP_STARVE_GUARD_EN
    logic [1:0] starve_cnt_r;

    // Count update grants that bypassed a waiting lookup, saturating at 2.
    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt_r <= 2'd0;
        end else if (lk_acc_s || !lk_valid) begin
            starve_cnt_r <= 2'd0;
        end else if (upd_acc_s && (starve_cnt_r != 2'd2)) begin
            starve_cnt_r <= starve_cnt_r + 2'd1;
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

    assign force_lk_s = lk_valid & (starve_cnt_r == 2'd2);
`else
    assign force_lk_s = 1'b0;
`endif

    // Single-access arbitration: update has priority unless a lookup is forced.
    assign upd_ready = run_s & ~force_lk_s;
    assign lk_ready  = run_s & (~upd_valid | force_lk_s);
    assign lk_acc_s  = lk_valid & lk_ready;
    assign upd_acc_s = upd_valid & upd_ready;

    assign init_busy  = ~run_s;
    assign pred_valid = pred_valid_r;
    assign pred_taken = pred_taken_r;

    // Select the table write: init sweep entry, accepted update, or none.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_idx_s  = sweep_idx_r;
        wr_data_s = 2'b01;
        if (reset) begin
            wr_en_s = 1'b0;
        end else if (!run_s) begin
            wr_en_s   = 1'b1;
            wr_idx_s  = sweep_idx_r;
            wr_data_s = 2'b01;
        end else if (upd_acc_s) begin
            wr_en_s   = 1'b1;
            wr_idx_s  = upd_idx_s;
            wr_data_s = sat_next(table_r[upd_idx_s], upd_taken);
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Counter storage; contents are established by the init sweep, not reset.
    always_ff @(posedge clock) begin
        if (wr_en_s) begin
            table_r[wr_idx_s] <= wr_data_s;
        end
    end

    // INIT/RUN control and sweep index.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_INIT;
            sweep_idx_r <= {IDX_W{1'b0}};
        end else begin
            case (state_r)
                ST_INIT: begin
                    if (sweep_idx_r == {IDX_W{1'b1}}) begin
                        state_r     <= ST_RUN;
                        sweep_idx_r <= {IDX_W{1'b0}};
                    end else begin
                        state_r     <= ST_INIT;
                        sweep_idx_r <= sweep_idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_RUN: begin
                    state_r     <= ST_RUN;
                    sweep_idx_r <= sweep_idx_r;
                end
                default: begin
                    state_r     <= ST_INIT;
                    sweep_idx_r <= {IDX_W{1'b0}};
                end
            endcase
        end
    end

    // Register the prediction of an accepted lookup for one cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            pred_valid_r <= 1'b0;
            pred_taken_r <= 1'b0;
        end else if (lk_acc_s) begin
            pred_valid_r <= 1'b1;
            pred_taken_r <= table_r[lk_idx_s][1];
        end else begin
            pred_valid_r <= 1'b0;
            pred_taken_r <= pred_taken_r;
        end
    end

endmodule

// File: tb/tb_bp_table_ctrl.sv
// Directed self-checking bench for bp_table_ctrl (default parameters).
module tb_bp_table_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        lk_valid;
    logic [15:0] lk_pc;
    logic        lk_ready;
    logic        pred_valid;
    logic        pred_taken;
    logic        upd_valid;
    logic [15:0] upd_pc;
    logic        upd_taken;
    logic        upd_ready;
    logic        init_busy;

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct {
        logic        uv;
        logic [15:0] upc;
        logic        ut;
        logic        lv;
        logic [15:0] lpc;
        logic        epv;
        logic        ept;
    } vec_t;

    vec_t vecs [28];

    bp_table_ctrl #(.IDX_W(4), .PC_W(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .lk_valid   (lk_valid),
        .lk_pc      (lk_pc),
        .lk_ready   (lk_ready),
        .pred_valid (pred_valid),
        .pred_taken (pred_taken),
        .upd_valid  (upd_valid),
        .upd_pc     (upd_pc),
        .upd_taken  (upd_taken),
        .upd_ready  (upd_ready),
        .init_busy  (init_busy)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic uv, input logic [15:0] upc, input logic ut,
                                input logic lv, input logic [15:0] lpc,
                                input logic epv, input logic ept);
        vec_t v;
        v.uv = uv; v.upc = upc; v.ut = ut;
        v.lv = lv; v.lpc = lpc; v.epv = epv; v.ept = ept;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Count INIT cycles from the current (first post-reset) cycle; both
    // requesters are held valid to prove neither is accepted during the sweep.
    task automatic wait_init(input string name);
        int cnt;
        int viol;
        cnt = 0;
        viol = 0;
        lk_valid = 1'b1; lk_pc = 16'h0001;
        upd_valid = 1'b1; upd_pc = 16'h0002; upd_taken = 1'b1;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (!init_busy) break;
            cnt++;
            if (lk_ready || upd_ready) viol++;
            step();
        end
        lk_valid = 1'b0;
        upd_valid = 1'b0;
        chk({name, "_len"}, cnt, 32'd16);
        chk({name, "_rdy"}, viol, 32'd0);
    endtask

    task automatic do_lookup(input string name, input logic [15:0] pc, input logic exp_t);
        lk_valid = 1'b1;
        lk_pc = pc;
        step();
        lk_valid = 1'b0;
        chk({name, "_pv"}, pred_valid, 1'b1);
        chk({name, "_pt"}, pred_taken, exp_t);
    endtask

    task automatic do_update(input logic [15:0] pc, input logic t);
        upd_valid = 1'b1;
        upd_pc = pc;
        upd_taken = t;
        step();
        upd_valid = 1'b0;
    endtask

    initial begin
        int grant;
        int exp_grant;
        int pv_cnt;

        reset = 1'b1;
        lk_valid = 1'b0; lk_pc = 16'h0000;
        upd_valid = 1'b0; upd_pc = 16'h0000; upd_taken = 1'b0;

        vecs[0]  = mk(1'b1, 16'h0005, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        vecs[1]  = mk(1'b1, 16'h0005, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        vecs[2]  = mk(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0005, 1'b1, 1'b1);
        vecs[3]  = mk(1'b1, 16'h0005, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        vecs[4]  = mk(1'b1, 16'h0005, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        vecs[5]  = mk(1'b1, 16'h0005, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        vecs[6]  = mk(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0005, 1'b1, 1'b1);
        vecs[7]  = mk(1'b1, 16'h0005, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        vecs[8]  = mk(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0005, 1'b1, 1'b0);
        vecs[9]  = mk(1'b1, 16'h0005, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        vecs[10] = mk(1'b1, 16'h0005, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        vecs[11] = mk(1'b1, 16'h0005, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        vecs[12] = mk(1'b1, 16'h0005, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        vecs[13] = mk(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0005, 1'b1, 1'b0);
        vecs[14] = mk(1'b1, 16'h0005, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        vecs[15] = mk(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0005, 1'b1, 1'b0);
        vecs[16] = mk(1'b1, 16'h0005, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        vecs[17] = mk(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0005, 1'b1, 1'b1);
        vecs[18] = mk(1'b1, 16'h0013, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        vecs[19] = mk(1'b1, 16'h0013, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        vecs[20] = mk(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0003, 1'b1, 1'b1);
        vecs[21] = mk(1'b1, 16'h0009, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        vecs[22] = mk(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0009, 1'b1, 1'b1);
        vecs[23] = mk(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        vecs[24] = mk(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0005, 1'b1, 1'b1);
        vecs[25] = mk(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0003, 1'b1, 1'b1);
        vecs[26] = mk(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
        vecs[27] = mk(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);

        // Reset held for three cycles, then release.
        repeat (3) step();
        chk("rst_pred_valid", pred_valid, 1'b0);
        chk("rst_pred_taken", pred_taken, 1'b0);
        chk("rst_init_busy", init_busy, 1'b1);
        chk("rst_lk_ready", lk_ready, 1'b0);
        chk("rst_upd_ready", upd_ready, 1'b0);
        reset = 1'b0;
        wait_init("init0");

        // Every entry starts weakly not-taken.
        for (int i = 0; i < 16; i++) begin
            do_lookup($sformatf("init_lk%0d", i), 16'(i), 1'b0);
        end

        // Directed vectors: saturation, aliasing, forwarding, back-to-back.
        for (int i = 0; i < 28; i++) begin
            upd_valid = vecs[i].uv; upd_pc = vecs[i].upc; upd_taken = vecs[i].ut;
            lk_valid = vecs[i].lv;  lk_pc = vecs[i].lpc;
            #1;
            chk($sformatf("vec%0d_lk_ready", i), lk_ready, !vecs[i].uv);
            chk($sformatf("vec%0d_upd_ready", i), upd_ready, 1'b1);
            step();
            chk($sformatf("vec%0d_pv", i), pred_valid, vecs[i].epv);
            if (vecs[i].epv) begin
                chk($sformatf("vec%0d_pt", i), pred_taken, vecs[i].ept);
            end
        end
        upd_valid = 1'b0;
        lk_valid = 1'b0;

        // Arbitration with both requesters continuously valid.
        pv_cnt = 0;
        lk_valid = 1'b1; lk_pc = 16'h0005;
        upd_valid = 1'b1; upd_pc = 16'h000A; upd_taken = 1'b0;
        for (int i = 0; i < 9; i++) begin
            #1;
            grant = (lk_ready ? 2 : 0) + (upd_ready ? 1 : 0);
`ifdef BP_STARVE_GUARD_EN
            exp_grant = ((i % 3) == 2) ? 2 : 1;
`else
            exp_grant = 1;
`endif
            chk($sformatf("arb_grant%0d", i), grant, exp_grant);
            step();
            if (pred_valid) pv_cnt++;
        end
        lk_valid = 1'b0;
        upd_valid = 1'b0;
`ifdef BP_STARVE_GUARD_EN
        chk("arb_pv_pulses", pv_cnt, 32'd3);
`else
        chk("arb_pv_pulses", pv_cnt, 32'd0);
`endif

        // Reset the cycle after a lookup acceptance; a held lookup is dropped.
        lk_valid = 1'b1; lk_pc = 16'h0005;
        step();
        chk("rstlk_pv_before", pred_valid, 1'b1);
        chk("rstlk_pt_before", pred_taken, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        lk_valid = 1'b0;
        chk("rstlk_pv_after", pred_valid, 1'b0);
        chk("rstlk_busy_after", init_busy, 1'b1);
        wait_init("init1");
        do_lookup("rstlk_retrain5", 16'h0005, 1'b0);

        // Train entry 5, then reset in the middle of the sweep (index 7).
        do_update(16'h0005, 1'b1);
        do_update(16'h0005, 1'b1);
        do_lookup("trained5", 16'h0005, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (7) step();
        chk("mid_busy", init_busy, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_pv", pred_valid, 1'b0);
        wait_init("init2");
        do_lookup("mid_lk5", 16'h0005, 1'b0);
        do_lookup("mid_lk15", 16'h000F, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/bp_table_ctrl.md
# bp_table_ctrl

Branch-history table controller for the fetch/execute branch-prediction path. It owns a table of 2-bit saturating counters and shares that table, one access per cycle, between two requesters: the fetch-stage lookup port and the execute-stage resolution update port. It clears the table with a multi-cycle init sweep after reset. Its `pred_taken` output is the history input to the branch-prediction PC-mux decision logic.

## Interface
- `IDX_W`, default 4: table index width; the table has 2^IDX_W entries.
- `PC_W`, default 16: PC width.
- `clock` in 1: single clock; all state changes on posedge.
- `reset` in 1: synchronous, active-high.
- `lk_valid` in 1: fetch lookup request.
- `lk_pc` in PC_W: lookup PC.
- `lk_ready` out 1: lookup accepted this cycle when `lk_valid & lk_ready`.
- `pred_valid` out 1: prediction result valid.
- `pred_taken` out 1: predicted direction, equal to bit 1 of the counter.
- `upd_valid` in 1: resolved-branch update request.
- `upd_pc` in PC_W: PC of the resolved branch.
- `upd_taken` in 1: actual branch outcome.
- `upd_ready` out 1: update accepted this cycle when `upd_valid & upd_ready`.
- `init_busy` out 1: init sweep in progress.

## Operation
- **Index:** `pc[IDX_W-1:0]` for both ports.
- **States:** INIT, RUN.
- **INIT:** `sweep_idx` counts 0 .. 2^IDX_W-1, writing 2'b01 (weakly not-taken) to one entry per cycle. After the last entry is written, the next state is RUN.
- **INIT outputs:** `lk_ready = upd_ready = 0`, `init_busy = 1`.
- **RUN:** exactly one table access per cycle (arbitration).
  - `force_lk = lk_valid & (starve_cnt == 2)`.
  - `upd_ready = RUN & ~force_lk`.
  - `lk_ready = RUN & (~upd_valid | force_lk)`.
  - `lk_ready` and `upd_ready` are combinational from state, `starve_cnt`, `lk_valid` and `upd_valid`.
  - They are never both accepted in the same cycle when both requests are valid.
- **Update:** on acceptance, the counter saturates:
  - taken: 00→01→10→11, and 11 stays 11;
  - not-taken: 11→10→01→00, and 00 stays 00.
- **Lookup:** on acceptance, register the entry into `pred_taken` and set `pred_valid = 1` for one cycle. `pred_valid = 0` in every cycle following a non-accepted cycle.
- **`starve_cnt`** (2-bit):
  - increments when an update is accepted while `lk_valid = 1`;
  - clears on lookup acceptance or when `lk_valid = 0`;
  - saturates at 2.
- **Reset:** `reset` in any state, including mid-sweep or mid-traffic, returns to INIT with `sweep_idx = 0`. Any accepted-but-unreported lookup is dropped.
- **Reset values:**
  - `pred_valid = 0`, `pred_taken = 0`;
  - `init_busy = 1`, `lk_ready = 0`, `upd_ready = 0`;
  - `starve_cnt = 0`.

## Timing
- **Init:** reset is released after cycle R. INIT then occupies cycles R+1 .. R+2^IDX_W (16 cycles by default), and the first RUN cycle is R+2^IDX_W+1, where `init_busy = 0`.
- **Lookup latency:** accept in cycle N, result on `pred_valid`/`pred_taken` in cycle N+1. Back-to-back lookups produce back-to-back results.
- **Update write:** takes effect at the end of the accept cycle. A lookup of the same index accepted in cycle N+1 sees the updated value; there is no stale read.
- **Starvation guard:** with both ports continuously valid, the grant pattern is upd, upd, lk, upd, upd, lk, and so on.
- **Hold rule:** requesters hold `*_valid` and payload until accepted. The block does not capture payload from non-accepted cycles.

## Configuration
- **`BP_STARVE_GUARD_EN` defined:** the starvation guard operates as described above.
- **Not defined:**
  - `force_lk` is tied to 0 and `starve_cnt` is removed;
  - update always wins (`lk_ready = RUN & ~upd_valid`, `upd_ready = RUN`);
  - all other behaviour is identical.

## Test plan
- **Reset/init:** hold `reset` 3 cycles, then release.
  - `init_busy = 1` for exactly 16 cycles, and `lk_ready = upd_ready = 0` throughout.
  - A lookup of every index 0–15 then returns `pred_taken = 0`.
- **Saturation:** 4 taken updates to `upd_pc = 16'h0005`, then a lookup.
  - After the 2nd update, a lookup gives `pred_taken = 1`; after the 4th, the counter is 11.
  - 1 not-taken update still gives `pred_taken = 1`; a 2nd not-taken gives 0.
  - 4 more not-taken leave it at 00, with no wrap to 11.
- **Aliasing and forwarding:**
  - Update `16'h0013`, taken ×2, then look up `16'h0003` (same index 3) → `pred_taken = 1`.
  - Update in cycle N, lookup same index in N+1 → result in N+2 reflects the update.
- **Arbitration:** `lk_valid` and `upd_valid` held high for 9 cycles.
  - With `BP_STARVE_GUARD_EN`: grants are U,U,L,U,U,L,U,U,L, and `pred_valid` pulses 3 times.
  - Without it: 9 update grants, 0 lookups.
- **Reset mid-operation:** assert `reset` during sweep index 7, and separately the cycle after a lookup acceptance.
  - `pred_valid = 0` in the next cycle.
  - The full 16-cycle sweep restarts, and a previously trained entry reads back not-taken.
